// File: rtl/clk_mon_pkg.sv
// Shared types for the clock-glitch monitor: FSM state encoding, the hi/lo
// sample pair and the absolute-difference helper used by the comparators.
package clk_mon_pkg;

   // Widest per-phase tick count the helper types can carry.
   localparam int unsigned SampleMaxW = 16;

   typedef logic [SampleMaxW-1:0] sample_t;

   typedef struct packed {
      sample_t hi;
      sample_t lo;
   } sample_pair_t;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StWarmup  = 3'd1,
      StCalib   = 3'd2,
      StMonitor = 3'd3,
      StAlarm   = 3'd4,
      StFault   = 3'd5
   } mon_state_e;

   // Larger minus smaller, so the result never wraps.
   function automatic sample_t abs_diff(input sample_t a, input sample_t b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/clk_glitch_monitor_ctrl_if.sv
// Control/status bundle between the RO counter / alarm logic and the glitch
// monitor sequencer. The monitor itself connects through the slave modport.
interface clk_glitch_monitor_ctrl_if #(
   parameter int unsigned NUM_RO = 4,
   parameter int unsigned CW     = 4
);
   logic              start;
   logic              stop;
   logic              clear_alarm;
   logic [NUM_RO-1:0] ro_mask;
   logic [CW-1:0]     tol;
   logic              sample_valid;
   logic [CW-1:0]     sample_hi;
   logic [CW-1:0]     sample_lo;

   logic [NUM_RO-1:0] ro_en;
   logic [2:0]        state_o;
   logic              calibrated;
   logic [CW-1:0]     baseline_hi;
   logic [CW-1:0]     baseline_lo;
   logic              glitch;
   logic              alarm;
   logic              cal_fail;

   modport master (
      output start, stop, clear_alarm, ro_mask, tol, sample_valid, sample_hi, sample_lo,
      input  ro_en, state_o, calibrated, baseline_hi, baseline_lo, glitch, alarm, cal_fail
   );

   modport slave (
      input  start, stop, clear_alarm, ro_mask, tol, sample_valid, sample_hi, sample_lo,
      output ro_en, state_o, calibrated, baseline_hi, baseline_lo, glitch, alarm, cal_fail
   );

endinterface

// File: rtl/clk_mon_cal_avg.sv
// Calibration averager: accumulates 2**LOG2_CAL hi/lo sample pairs and
// presents their truncated mean together with a done strobe on the last one.
module clk_mon_cal_avg #(
   parameter int unsigned CW       = 4,
   parameter int unsigned LOG2_CAL = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          valid_i,
   input  logic [CW-1:0] sample_hi_i,
   input  logic [CW-1:0] sample_lo_i,
   output logic          done_o,
   output logic [CW-1:0] baseline_hi_o,
   output logic [CW-1:0] baseline_lo_o
);

   localparam int unsigned AccW   = CW + LOG2_CAL;
   localparam int unsigned NumCal = 2 ** LOG2_CAL;
   localparam int unsigned CntW   = LOG2_CAL + 1;

   logic [AccW-1:0] acc_hi_q, acc_hi_d;
   logic [AccW-1:0] acc_lo_q, acc_lo_d;
   logic [AccW-1:0] sum_hi, sum_lo;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Sums include the current sample so the baseline is ready in the same
   // cycle as the final sample; the accumulators restart after done.
   always_comb begin
      sum_hi        = acc_hi_q + AccW'(sample_hi_i);
      sum_lo        = acc_lo_q + AccW'(sample_lo_i);
      done_o        = valid_i && (cnt_q == CntW'(NumCal - 1));
      baseline_hi_o = CW'(sum_hi >> LOG2_CAL);
      baseline_lo_o = CW'(sum_lo >> LOG2_CAL);
      acc_hi_d      = acc_hi_q;
      acc_lo_d      = acc_lo_q;
      cnt_d         = cnt_q;
      if (clr_i || done_o) begin
         acc_hi_d = '0;
         acc_lo_d = '0;
         cnt_d    = '0;
      end else if (valid_i) begin
         acc_hi_d = sum_hi;
         acc_lo_d = sum_lo;
         cnt_d    = cnt_q + CntW'(1);
      end
   end

   // Accumulator and sample-count registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/clk_glitch_monitor_ctrl.sv
// Ring-oscillator clock-glitch monitor sequencer: warm-up, baseline
// calibration, per-sample tolerance checking and sticky alarm escalation.
module clk_glitch_monitor_ctrl
   import clk_mon_pkg::*;
#(
   parameter int unsigned NUM_RO     = 4,
   parameter int unsigned CW         = 4,
   parameter int unsigned LOG2_CAL   = 3,
   parameter int unsigned WARMUP_CYC = 16,
   parameter int unsigned ALARM_CNT  = 2
) (
   input logic                      clk,
   input logic                      rst,
   clk_glitch_monitor_ctrl_if.slave bus
);

   localparam int unsigned WarmW = $clog2(WARMUP_CYC + 1);
   localparam int unsigned ViolW = $clog2(ALARM_CNT + 1);

   mon_state_e        state_q;
   logic [WarmW-1:0]  warm_cnt_q;
   logic [ViolW-1:0]  viol_cnt_q;
   logic [ViolW-1:0]  viol_inc;
   logic [NUM_RO-1:0] ro_en_q;
   logic              calibrated_q;
   logic [CW-1:0]     base_hi_q, base_lo_q;
   logic              glitch_q;
   logic              alarm_q;
   logic              cal_fail_q;

   sample_pair_t      cur_sample, cur_base;
   sample_t           diff_hi, diff_lo;
   logic              viol;
   logic              alarm_hit;

   logic              cal_clr, cal_valid, cal_done, cal_bad;
   logic [CW-1:0]     cal_base_hi, cal_base_lo;

   // Accumulators only run in CALIB and are flushed by stop or any other state.
   assign cal_clr   = (state_q != StCalib) || bus.stop;
   assign cal_valid = (state_q == StCalib) && bus.sample_valid && !bus.stop;

   clk_mon_cal_avg #(
      .CW       (CW),
      .LOG2_CAL (LOG2_CAL)
   ) u_cal_avg (
      .clk_i         (clk),
      .rst_i         (rst),
      .clr_i         (cal_clr),
      .valid_i       (cal_valid),
      .sample_hi_i   (bus.sample_hi),
      .sample_lo_i   (bus.sample_lo),
      .done_o        (cal_done),
      .baseline_hi_o (cal_base_hi),
      .baseline_lo_o (cal_base_lo)
   );

   // Tolerance comparators and saturating violation-count look-ahead.
   always_comb begin
      cur_sample.hi = sample_t'(bus.sample_hi);
      cur_sample.lo = sample_t'(bus.sample_lo);
      cur_base.hi   = sample_t'(base_hi_q);
      cur_base.lo   = sample_t'(base_lo_q);
      diff_hi       = abs_diff(cur_sample.hi, cur_base.hi);
      diff_lo       = abs_diff(cur_sample.lo, cur_base.lo);
      viol          = bus.sample_valid &&
                      ((diff_hi > sample_t'(bus.tol)) || (diff_lo > sample_t'(bus.tol)));
      viol_inc      = (viol_cnt_q == ViolW'(ALARM_CNT)) ? viol_cnt_q : viol_cnt_q + ViolW'(1);
      alarm_hit     = viol && (viol_inc == ViolW'(ALARM_CNT));
      cal_bad       = (cal_base_hi == '0) || (cal_base_hi == '1) ||
                      (cal_base_lo == '0) || (cal_base_lo == '1);
   end

   // Sequencer FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         warm_cnt_q   <= '0;
         viol_cnt_q   <= '0;
         ro_en_q      <= '0;
         calibrated_q <= 1'b0;
         base_hi_q    <= '0;
         base_lo_q    <= '0;
         glitch_q     <= 1'b0;
         alarm_q      <= 1'b0;
         cal_fail_q   <= 1'b0;
      end else begin
         glitch_q <= 1'b0;
         unique case (state_q)
            StIdle, StFault: begin
               if (bus.start) begin
                  state_q      <= StWarmup;
                  ro_en_q      <= bus.ro_mask;
                  cal_fail_q   <= 1'b0;
                  calibrated_q <= 1'b0;
                  base_hi_q    <= '0;
                  base_lo_q    <= '0;
                  warm_cnt_q   <= '0;
               end else begin
                  ro_en_q <= '0;
               end
            end
            StWarmup: begin
               if (bus.stop) begin
                  state_q      <= StIdle;
                  ro_en_q      <= '0;
                  calibrated_q <= 1'b0;
                  viol_cnt_q   <= '0;
               end else begin
                  ro_en_q    <= bus.ro_mask;
                  warm_cnt_q <= warm_cnt_q + WarmW'(1);
                  if (warm_cnt_q == WarmW'(WARMUP_CYC - 1)) begin
                     state_q <= StCalib;
                  end
               end
            end
            StCalib: begin
               if (bus.stop) begin
                  state_q      <= StIdle;
                  ro_en_q      <= '0;
                  calibrated_q <= 1'b0;
                  viol_cnt_q   <= '0;
               end else if (cal_done) begin
                  base_hi_q <= cal_base_hi;
                  base_lo_q <= cal_base_lo;
                  if (cal_bad) begin
                     state_q    <= StFault;
                     cal_fail_q <= 1'b1;
                     ro_en_q    <= '0;
                  end else begin
                     state_q      <= StMonitor;
                     calibrated_q <= 1'b1;
                     ro_en_q      <= bus.ro_mask;
                  end
               end else begin
                  ro_en_q <= bus.ro_mask;
               end
            end
            StMonitor: begin
               if (viol) begin
                  glitch_q   <= 1'b1;
                  viol_cnt_q <= viol_inc;
               end else if (bus.sample_valid) begin
                  viol_cnt_q <= '0;
               end
               // An alarm-raising sample outranks a simultaneous stop.
               if (alarm_hit) begin
                  state_q <= StAlarm;
                  alarm_q <= 1'b1;
                  ro_en_q <= bus.ro_mask;
               end else if (bus.stop) begin
                  state_q      <= StIdle;
                  ro_en_q      <= '0;
                  calibrated_q <= 1'b0;
                  viol_cnt_q   <= '0;
               end else begin
                  ro_en_q <= bus.ro_mask;
               end
            end
            StAlarm: begin
               if (bus.clear_alarm) begin
                  state_q      <= StIdle;
                  alarm_q      <= 1'b0;
                  calibrated_q <= 1'b0;
                  viol_cnt_q   <= '0;
                  ro_en_q      <= '0;
               end else begin
                  ro_en_q <= bus.ro_mask;
               end
            end
            default: begin
               state_q <= StIdle;
               ro_en_q <= '0;
            end
         endcase
      end
   end

   assign bus.ro_en       = ro_en_q;
   assign bus.state_o     = state_q;
   assign bus.calibrated  = calibrated_q;
   assign bus.baseline_hi = base_hi_q;
   assign bus.baseline_lo = base_lo_q;
   assign bus.glitch      = glitch_q;
   assign bus.alarm       = alarm_q;
   assign bus.cal_fail    = cal_fail_q;

endmodule

// File: tb/tb_clk_glitch_monitor_ctrl.sv
// Bench for the clock-glitch monitor: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model.
module tb_clk_glitch_monitor_ctrl;

   localparam int NumRo     = 4;
   localparam int Cw        = 4;
   localparam int Log2Cal   = 3;
   localparam int NumCal    = 8;
   localparam int WarmupCyc = 16;
   localparam int AlarmCnt  = 2;
   localparam int MaxVal    = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   clk_glitch_monitor_ctrl_if #(.NUM_RO(NumRo), .CW(Cw)) bus ();

   clk_glitch_monitor_ctrl #(
      .NUM_RO     (NumRo),
      .CW         (Cw),
      .LOG2_CAL   (Log2Cal),
      .WARMUP_CYC (WarmupCyc),
      .ALARM_CNT  (AlarmCnt)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: mode number, counters and sample history.
   int m_state, m_ro_en, m_cal, m_bhi, m_blo, m_glitch, m_alarm, m_calfail;
   int m_warm, m_viol;
   int cal_hi_q[$];
   int cal_lo_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic int clamp(input int v);
      if (v < 0) return 0;
      if (v > MaxVal) return MaxVal;
      return v;
   endfunction

   task automatic model_go_idle();
      m_state = 0;
      m_cal   = 0;
      m_viol  = 0;
      cal_hi_q.delete();
      cal_lo_q.delete();
   endtask

   task automatic model_step();
      int sh, sl, tl, avg_hi, avg_lo;
      bit v;
      if (rst) begin
         m_state = 0; m_ro_en = 0; m_cal = 0; m_bhi = 0; m_blo = 0;
         m_glitch = 0; m_alarm = 0; m_calfail = 0; m_warm = 0; m_viol = 0;
         cal_hi_q.delete();
         cal_lo_q.delete();
         return;
      end
      sh = int'(bus.sample_hi);
      sl = int'(bus.sample_lo);
      tl = int'(bus.tol);
      m_glitch = 0;
      case (m_state)
         0, 5: begin
            if (bus.start) begin
               m_state = 1; m_calfail = 0; m_cal = 0; m_bhi = 0; m_blo = 0; m_warm = 0;
               cal_hi_q.delete();
               cal_lo_q.delete();
            end
         end
         1: begin
            if (bus.stop) model_go_idle();
            else begin
               m_warm++;
               if (m_warm == WarmupCyc) m_state = 2;
            end
         end
         2: begin
            if (bus.stop) model_go_idle();
            else if (bus.sample_valid) begin
               cal_hi_q.push_back(sh);
               cal_lo_q.push_back(sl);
               if (cal_hi_q.size() == NumCal) begin
                  avg_hi = 0;
                  avg_lo = 0;
                  foreach (cal_hi_q[k]) begin
                     avg_hi += cal_hi_q[k];
                     avg_lo += cal_lo_q[k];
                  end
                  m_bhi = avg_hi / NumCal;
                  m_blo = avg_lo / NumCal;
                  if (m_bhi == 0 || m_bhi == MaxVal || m_blo == 0 || m_blo == MaxVal) begin
                     m_state   = 5;
                     m_calfail = 1;
                  end else begin
                     m_state = 3;
                     m_cal   = 1;
                  end
                  cal_hi_q.delete();
                  cal_lo_q.delete();
               end
            end
         end
         3: begin
            v = 1'b0;
            if (bus.sample_valid) begin
               v = (absd(sh, m_bhi) > tl) || (absd(sl, m_blo) > tl);
               if (v) begin
                  m_glitch = 1;
                  if (m_viol < AlarmCnt) m_viol++;
               end else begin
                  m_viol = 0;
               end
            end
            if (v && m_viol >= AlarmCnt) begin
               m_alarm = 1;
               m_state = 4;
            end else if (bus.stop) begin
               model_go_idle();
            end
         end
         4: begin
            if (bus.clear_alarm) begin
               m_state = 0; m_alarm = 0; m_cal = 0; m_viol = 0;
            end
         end
         default: m_state = 0;
      endcase
      m_ro_en = (m_state >= 1 && m_state <= 4) ? int'(bus.ro_mask) : 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("state",       bus.state_o,     m_state);
      check("ro_en",       bus.ro_en,       m_ro_en);
      check("calibrated",  bus.calibrated,  m_cal);
      check("baseline_hi", bus.baseline_hi, m_bhi);
      check("baseline_lo", bus.baseline_lo, m_blo);
      check("glitch",      bus.glitch,      m_glitch);
      check("alarm",       bus.alarm,       m_alarm);
      check("cal_fail",    bus.cal_fail,    m_calfail);
   endtask

   task automatic idle_inputs();
      bus.start        = 1'b0;
      bus.stop         = 1'b0;
      bus.clear_alarm  = 1'b0;
      bus.sample_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Bounded: leaves as soon as the model has left WARMUP.
   task automatic wait_calib();
      for (int k = 0; k < WarmupCyc + 4 && m_state == 1; k++) tick();
      check("warmup_exit", bus.state_o, 2);
   endtask

   task automatic feed(input int hi, input int lo, input bit with_stop);
      bus.sample_valid = 1'b1;
      bus.sample_hi    = 4'(hi);
      bus.sample_lo    = 4'(lo);
      bus.stop         = with_stop;
      tick();
      bus.sample_valid = 1'b0;
      bus.stop         = 1'b0;
   endtask

   initial begin
      int center;
      rst          = 1'b1;
      idle_inputs();
      bus.ro_mask   = 4'b1011;
      bus.tol       = 4'd2;
      bus.sample_hi = '0;
      bus.sample_lo = '0;
      tick();
      tick();
      check("reset_state", bus.state_o, 0);
      check("reset_alarm", bus.alarm, 0);
      check("reset_ro_en", bus.ro_en, 0);
      rst = 1'b0;
      tick();

      // Happy path and tolerance edge.
      pulse_start();
      check("start_ro_en", bus.ro_en, 4'b1011);
      wait_calib();
      repeat (NumCal) feed(8, 8, 1'b0);
      check("happy_state", bus.state_o, 3);
      check("happy_base_hi", bus.baseline_hi, 8);
      check("happy_cal", bus.calibrated, 1);
      feed(10, 8, 1'b0);
      check("tol_edge_clean", bus.glitch, 0);
      feed(11, 8, 1'b0);
      check("tol_over_glitch", bus.glitch, 1);
      bus.clear_alarm = 1'b1;
      tick();
      bus.clear_alarm = 1'b0;
      check("clear_in_monitor", bus.state_o, 3);

      // Escalation: isolated violations never alarm, two in a row do.
      feed(8, 8, 1'b0);
      feed(8, 3, 1'b0);
      feed(8, 8, 1'b0);
      feed(13, 8, 1'b0);
      check("isolated_no_alarm", bus.alarm, 0);
      feed(8, 8, 1'b0);
      feed(2, 8, 1'b0);
      check("first_viol_no_alarm", bus.alarm, 0);
      feed(14, 8, 1'b0);
      check("escalate_alarm", bus.alarm, 1);
      check("escalate_state", bus.state_o, 4);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      idle_inputs();
      check("alarm_ignores_start", bus.state_o, 4);

      // Reset while alarmed.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_alarm", bus.alarm, 0);
      check("rst_base", bus.baseline_hi, 0);
      tick();

      // Calibration fault and recovery.
      pulse_start();
      wait_calib();
      repeat (NumCal) feed(0, 0, 1'b0);
      check("fault_state", bus.state_o, 5);
      check("fault_cal_fail", bus.cal_fail, 1);
      check("fault_ro_en", bus.ro_en, 0);
      pulse_start();
      check("restart_cal_fail", bus.cal_fail, 0);
      wait_calib();
      for (int k = 0; k < NumCal; k++) feed(7 + (k % 2), 9, 1'b0);
      check("recal_state", bus.state_o, 3);
      check("recal_base_hi", bus.baseline_hi, 7);

      // Stop mid-calibration flushes the accumulators.
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      pulse_start();
      wait_calib();
      repeat (3) feed(12, 12, 1'b0);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check("stop_calib_state", bus.state_o, 0);
      check("stop_calib_ro_en", bus.ro_en, 0);
      pulse_start();
      wait_calib();
      repeat (NumCal) feed(5, 6, 1'b0);
      check("post_stop_base_lo", bus.baseline_lo, 6);

      // Alarm-raising sample beats stop.
      bus.tol = 4'd1;
      feed(9, 6, 1'b0);
      feed(9, 6, 1'b1);
      check("race_state", bus.state_o, 4);
      bus.clear_alarm = 1'b1;
      tick();
      bus.clear_alarm = 1'b0;
      check("clear_alarm_state", bus.state_o, 0);

      // Random traffic.
      center = 8;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) center = int'($urandom_range(0, MaxVal));
         rst              = ($urandom_range(0, 255) == 0);
         bus.start        = ($urandom_range(0, 15) == 0);
         bus.stop         = ($urandom_range(0, 47) == 0);
         bus.clear_alarm  = ($urandom_range(0, 15) == 0);
         bus.ro_mask      = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) bus.tol = 4'($urandom_range(0, 3));
         bus.sample_valid = 1'($urandom_range(0, 1));
         bus.sample_hi    = 4'(clamp(center + int'($urandom_range(0, 6)) - 3));
         bus.sample_lo    = 4'(clamp(center + int'($urandom_range(0, 6)) - 3));
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
